// File: rtl/ir_pkg.sv
// Shared types and NEC timing thresholds (in 50 MHz cycles) for the IR pulse meter.
package ir_pkg;

  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int NEC_LEAD_LOW_MIN  = 400000;
  localparam int NEC_LEAD_HIGH_MIN = 180000;
  localparam int NEC_REP_HIGH_MIN  = 90000;
  localparam int NEC_BIT_MIN       = 20000;
  localparam int NEC_BIT_LOW_MAX   = 40000;
  localparam int NEC_ONE_HIGH_MIN  = 41500;
  localparam int NEC_ONE_HIGH_MAX  = 100000;

  typedef enum logic [2:0] {
    SYM_ZERO   = 3'd0,
    SYM_ONE    = 3'd1,
    SYM_LEAD   = 3'd2,
    SYM_REPEAT = 3'd3,
    SYM_IDLE   = 3'd4,
    SYM_ERR    = 3'd5
  } sym_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_STUCK = 2'd3
  } state_e;

endpackage

// File: rtl/ir_glitch_filter.sv
// Two-flop synchronizer followed by a persistence filter: the output follows
// the input only after FILT_LEN consecutive disagreeing cycles.
module ir_glitch_filter #(
  parameter int FILT_LEN = 16
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic din,
  output logic dout
);

  localparam int FW = $clog2(FILT_LEN + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [FW-1:0] filt_cnt;

  // Stage 0/1: metastability guard for the asynchronous receiver line
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: any agreeing cycle restarts the run, so edge delay is identical both ways
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      dout     <= 1'b1;
      filt_cnt <= '0;
    end else if (sync_p1 == dout) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      dout     <= sync_p1;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

endmodule

// File: rtl/ir_pulse_meter.sv
// Measures filtered IR low/high phase lengths and classifies each pair as an
// NEC symbol, emitting a one-cycle strobe with the code and measured lengths.
module ir_pulse_meter
  import ir_pkg::*;
#(
  parameter int FILT_LEN      = 16,
  parameter int IDLE_TIMEOUT  = 550000,
  parameter int LEAD_LOW_MIN  = NEC_LEAD_LOW_MIN,
  parameter int LEAD_HIGH_MIN = NEC_LEAD_HIGH_MIN,
  parameter int REP_HIGH_MIN  = NEC_REP_HIGH_MIN,
  parameter int BIT_MIN       = NEC_BIT_MIN,
  parameter int BIT_LOW_MAX   = NEC_BIT_LOW_MAX,
  parameter int ONE_HIGH_MIN  = NEC_ONE_HIGH_MIN,
  parameter int ONE_HIGH_MAX  = NEC_ONE_HIGH_MAX
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              IRDA_RXD,
  output logic              sym_valid,
  output logic [2:0]        sym_code,
  output logic [CNT_W-1:0]  low_len,
  output logic [CNT_W-1:0]  high_len,
  output logic              rx_level,
  output logic              busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] TH_LEAD_LOW  = CNT_W'(LEAD_LOW_MIN);
  localparam logic [CNT_W-1:0] TH_LEAD_HIGH = CNT_W'(LEAD_HIGH_MIN);
  localparam logic [CNT_W-1:0] TH_REP_HIGH  = CNT_W'(REP_HIGH_MIN);
  localparam logic [CNT_W-1:0] TH_BIT_MIN   = CNT_W'(BIT_MIN);
  localparam logic [CNT_W-1:0] TH_BIT_LOW   = CNT_W'(BIT_LOW_MAX);
  localparam logic [CNT_W-1:0] TH_ONE_MIN   = CNT_W'(ONE_HIGH_MIN);
  localparam logic [CNT_W-1:0] TH_ONE_MAX   = CNT_W'(ONE_HIGH_MAX);

  function automatic sym_code_e classify(input logic [CNT_W-1:0] lo,
                                         input logic [CNT_W-1:0] hi);
    if (lo >= TH_LEAD_LOW && hi >= TH_LEAD_HIGH)
      return SYM_LEAD;
    if (lo >= TH_LEAD_LOW && hi >= TH_REP_HIGH && hi < TH_LEAD_HIGH)
      return SYM_REPEAT;
    if (lo >= TH_BIT_MIN && lo <= TH_BIT_LOW && hi >= TH_BIT_MIN && hi < TH_ONE_MIN)
      return SYM_ZERO;
    if (lo >= TH_BIT_MIN && lo <= TH_BIT_LOW && hi >= TH_ONE_MIN && hi <= TH_ONE_MAX)
      return SYM_ONE;
    return SYM_ERR;
  endfunction

  state_e           state;
  state_e           state_nxt;
  logic             rx_prev_p1;
  logic             rise;
  logic             fall;
  logic             timeout;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] low_meas;

  logic             emit;
  sym_code_e        emit_code;
  logic [CNT_W-1:0] emit_low;
  logic [CNT_W-1:0] emit_high;
  logic             cnt_load;
  logic             cnt_clr;
  logic             low_latch;

  ir_glitch_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .din      (IRDA_RXD),
    .dout     (rx_level)
  );

  // Stage 3: edge detect on the filtered level
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) rx_prev_p1 <= 1'b1;
    else       rx_prev_p1 <= rx_level;
  end

  assign rise    = ~rx_prev_p1 & rx_level;
  assign fall    = rx_prev_p1 & ~rx_level;
  assign timeout = (cnt == TIMEOUT_C);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Falling edges win over a coincident timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fall) state_nxt = ST_LOW;
      ST_LOW: begin
        if (rise)         state_nxt = ST_HIGH;
        else if (timeout) state_nxt = ST_STUCK;
      end
      ST_HIGH: begin
        if (fall)         state_nxt = ST_LOW;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_STUCK: if (rise) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    emit      = 1'b0;
    emit_code = SYM_ERR;
    emit_low  = low_meas;
    emit_high = '0;
    cnt_load  = 1'b0;
    cnt_clr   = 1'b0;
    low_latch = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) cnt_load = 1'b1;
        else      cnt_clr  = 1'b1;
      end
      ST_LOW: begin
        if (rise) begin
          low_latch = 1'b1;
          cnt_load  = 1'b1;
        end else if (timeout) begin
          emit      = 1'b1;
          emit_code = SYM_ERR;
          emit_low  = cnt;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          emit      = 1'b1;
          emit_code = classify(low_meas, cnt);
          emit_high = cnt;
          cnt_load  = 1'b1;
        end else if (timeout) begin
          emit      = 1'b1;
          emit_code = SYM_IDLE;
          emit_high = TIMEOUT_C;
          cnt_clr   = 1'b1;
        end
      end
      ST_STUCK: if (rise) cnt_clr = 1'b1;
      default:  cnt_clr = 1'b1;
    endcase
  end

  // Phase counter saturates rather than wrapping on a dead line
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cnt      <= '0;
      low_meas <= '0;
    end else begin
      if (cnt_clr)             cnt <= '0;
      else if (cnt_load)       cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (low_latch) low_meas <= cnt;
    end
  end

  // Stage 4: published symbol; lengths only move together with the strobe
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sym_valid <= 1'b0;
      sym_code  <= '0;
      low_len   <= '0;
      high_len  <= '0;
    end else begin
      sym_valid <= emit;
      if (emit) begin
        sym_code <= emit_code;
        low_len  <= emit_low;
        high_len <= emit_high;
      end
    end
  end

endmodule

// File: tb/tb_ir_pulse_meter.sv
// Directed bench for ir_pulse_meter; thresholds are scaled down by 200 to keep run time short.
module tb_ir_pulse_meter;

  localparam int TO     = 2750;
  localparam int LEAD_L = 2250;
  localparam int LEAD_H = 1125;
  localparam int REP_H  = 562;
  localparam int BIT_L  = 140;
  localparam int ZERO_H = 140;
  localparam int ONE_H  = 421;

  localparam logic [2:0] C_ZERO = 3'd0, C_ONE = 3'd1, C_LEAD = 3'd2,
                         C_REP  = 3'd3, C_IDLE = 3'd4, C_ERR = 3'd5;

  logic        CLOCK_50;
  logic        RESET;
  logic        IRDA_RXD;
  logic        sym_valid;
  logic [2:0]  sym_code;
  logic [19:0] low_len;
  logic [19:0] high_len;
  logic        rx_level;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  code;
    logic [19:0] lo;
    logic [19:0] hi;
  } sym_t;
  sym_t q[$];

  ir_pulse_meter #(
    .FILT_LEN      (16),
    .IDLE_TIMEOUT  (TO),
    .LEAD_LOW_MIN  (2000),
    .LEAD_HIGH_MIN (900),
    .REP_HIGH_MIN  (450),
    .BIT_MIN       (100),
    .BIT_LOW_MAX   (200),
    .ONE_HIGH_MIN  (208),
    .ONE_HIGH_MAX  (500)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .IRDA_RXD  (IRDA_RXD),
    .sym_valid (sym_valid),
    .sym_code  (sym_code),
    .low_len   (low_len),
    .high_len  (high_len),
    .rx_level  (rx_level),
    .busy      (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (sym_valid === 1'b1) q.push_back('{sym_code, low_len, high_len});
  end

  task automatic phase(input logic lvl, input int n);
    IRDA_RXD = lvl;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    RESET    = 1'b1;
    IRDA_RXD = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    n_checks++; if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL rst_sym_valid: got %b want 0", sym_valid); end
    n_checks++; if (sym_code !== 3'd0) begin n_fail++; $display("FAIL rst_sym_code: got %0d want 0", sym_code); end
    n_checks++; if (low_len !== 20'd0) begin n_fail++; $display("FAIL rst_low_len: got %0d want 0", low_len); end
    n_checks++; if (high_len !== 20'd0) begin n_fail++; $display("FAIL rst_high_len: got %0d want 0", high_len); end
    n_checks++; if (rx_level !== 1'b1) begin n_fail++; $display("FAIL rst_rx_level: got %b want 1", rx_level); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    RESET = 1'b0;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic test_nec_frame(input logic [31:0] pat, input string tag);
    q.delete();
    phase(1'b0, LEAD_L);
    phase(1'b1, LEAD_H);
    for (int i = 0; i < 32; i++) begin
      phase(1'b0, BIT_L);
      phase(1'b1, pat[i] ? ONE_H : ZERO_H);
    end
    phase(1'b0, BIT_L);
    phase(1'b1, TO + 200);
    n_checks++;
    if (q.size() != 34) begin
      n_fail++; $display("FAIL %s_count: got %0d symbols want 34", tag, q.size());
    end else begin
      n_checks++; if (q[0].code !== C_LEAD) begin n_fail++; $display("FAIL %s_lead: got %0d want %0d", tag, q[0].code, C_LEAD); end
      n_checks++; if (q[0].lo !== 20'(LEAD_L) || q[0].hi !== 20'(LEAD_H)) begin
        n_fail++; $display("FAIL %s_lead_len: got %0d/%0d want %0d/%0d", tag, q[0].lo, q[0].hi, LEAD_L, LEAD_H); end
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (q[i+1].code !== (pat[i] ? C_ONE : C_ZERO)) begin
          n_fail++; $display("FAIL %s_bit%0d: got %0d want %0d", tag, i, q[i+1].code, pat[i]);
        end
      end
      n_checks++; if (q[2].lo !== 20'(BIT_L) || q[2].hi !== 20'(pat[1] ? ONE_H : ZERO_H)) begin
        n_fail++; $display("FAIL %s_bit1_len: got %0d/%0d", tag, q[2].lo, q[2].hi); end
      n_checks++; if (q[33].code !== C_IDLE || q[33].hi !== 20'(TO) || q[33].lo !== 20'(BIT_L)) begin
        n_fail++; $display("FAIL %s_idle: got code %0d lo %0d hi %0d want %0d/%0d/%0d",
                           tag, q[33].code, q[33].lo, q[33].hi, C_IDLE, BIT_L, TO); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end: got %b want 0", tag, busy); end
  endtask

  task automatic test_repeat();
    q.delete();
    phase(1'b0, LEAD_L);
    phase(1'b1, REP_H);
    phase(1'b0, BIT_L);
    phase(1'b1, TO + 200);
    n_checks++;
    if (q.size() != 2) begin
      n_fail++; $display("FAIL rep_count: got %0d want 2", q.size());
    end else begin
      n_checks++; if (q[0].code !== C_REP || q[0].hi !== 20'(REP_H)) begin
        n_fail++; $display("FAIL rep_code: got %0d hi %0d want %0d hi %0d", q[0].code, q[0].hi, C_REP, REP_H); end
      n_checks++; if (q[1].code !== C_IDLE) begin n_fail++; $display("FAIL rep_idle: got %0d want %0d", q[1].code, C_IDLE); end
    end
  endtask

  task automatic test_glitch();
    bit lvl_bad = 0;
    bit busy_bad = 0;
    q.delete();
    IRDA_RXD = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) IRDA_RXD = 1'b1;
      @(negedge CLOCK_50);
      if (rx_level !== 1'b1) lvl_bad = 1;
      if (busy !== 1'b0) busy_bad = 1;
    end
    n_checks++; if (lvl_bad) begin n_fail++; $display("FAIL glitch_level: rx_level left 1, want steady 1"); end
    n_checks++; if (busy_bad) begin n_fail++; $display("FAIL glitch_busy: busy went 1, want steady 0"); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL glitch_sym: got %0d symbols want 0", q.size()); end
  endtask

  task automatic test_stuck();
    q.delete();
    phase(1'b0, TO + 250);
    n_checks++;
    if (q.size() != 1) begin
      n_fail++; $display("FAIL stuck_count: got %0d want 1", q.size());
    end else begin
      n_checks++; if (q[0].code !== C_ERR) begin n_fail++; $display("FAIL stuck_code: got %0d want %0d", q[0].code, C_ERR); end
    end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stuck_busy: got %b want 1", busy); end
    phase(1'b1, TO + 200);
    n_checks++; if (q.size() != 1) begin n_fail++; $display("FAIL stuck_release: got %0d symbols want 1", q.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stuck_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_bit_bounds();
    q.delete();
    phase(1'b0, BIT_L); phase(1'b1, 225);
    phase(1'b0, BIT_L); phase(1'b1, 207);
    phase(1'b0, 75);    phase(1'b1, ZERO_H);
    phase(1'b0, BIT_L); phase(1'b1, TO + 200);
    n_checks++;
    if (q.size() != 4) begin
      n_fail++; $display("FAIL bounds_count: got %0d want 4", q.size());
    end else begin
      n_checks++; if (q[0].code !== C_ONE) begin n_fail++; $display("FAIL bounds_high225: got %0d want %0d", q[0].code, C_ONE); end
      n_checks++; if (q[1].code !== C_ZERO) begin n_fail++; $display("FAIL bounds_high207: got %0d want %0d", q[1].code, C_ZERO); end
      n_checks++; if (q[2].code !== C_ERR || q[2].lo !== 20'd75) begin
        n_fail++; $display("FAIL bounds_low75: got %0d lo %0d want %0d lo 75", q[2].code, q[2].lo, C_ERR); end
      n_checks++; if (q[3].code !== C_IDLE) begin n_fail++; $display("FAIL bounds_idle: got %0d want %0d", q[3].code, C_IDLE); end
    end
  endtask

  task automatic test_reset_midframe();
    q.delete();
    phase(1'b0, LEAD_L);
    phase(1'b1, LEAD_H);
    for (int i = 0; i < 10; i++) begin
      phase(1'b0, BIT_L);
      phase(1'b1, i[0] ? ONE_H : ZERO_H);
    end
    n_checks++; if (q.size() != 10) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 10", q.size()); end
    q.delete();
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    n_checks++; if (sym_valid !== 1'b0 || sym_code !== 3'd0 || low_len !== 20'd0 || high_len !== 20'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_outputs: got v%b c%0d lo%0d hi%0d b%b want all 0",
                         sym_valid, sym_code, low_len, high_len, busy); end
    n_checks++; if (rx_level !== 1'b1) begin n_fail++; $display("FAIL mid_rst_level: got %b want 1", rx_level); end
    RESET = 1'b0;
    phase(1'b1, TO + 200);
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL mid_no_strobe: got %0d symbols want 0", q.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    test_nec_frame(32'h6C93_01FE, "post_rst");
  endtask

  initial begin
    test_reset();
    test_nec_frame(32'hA55A_00FF, "nec");
    test_repeat();
    test_glitch();
    test_stuck();
    test_bit_bounds();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_pulse_meter.md
IR_PULSE_METER -- requirements
Module: ir_pulse_meter

Interface
REQ-001 Parameter FILT_LEN, 16, consecutive cycles of disagreement required before the filtered level changes.
REQ-002 Parameter IDLE_TIMEOUT, 550000, cycles of one filtered level that ends a frame.
REQ-003 Port CLOCK_50  input  1  single 50 MHz clock; all state changes on its rising edge.
REQ-004 Port RESET  input  1  asynchronous, active-high reset.
REQ-005 Port IRDA_RXD  input  1  raw IR receiver line, asynchronous, idle high.
REQ-006 Port sym_valid  output  1  one-cycle strobe marking a new symbol.
REQ-007 Port sym_code  output  3  symbol: 0 ZERO, 1 ONE, 2 LEAD, 3 REPEAT, 4 IDLE, 5 ERR.
REQ-008 Port low_len  output  20  measured low-phase length of the last symbol, in cycles.
REQ-009 Port high_len  output  20  measured high-phase length of the last symbol, in cycles.
REQ-010 Port rx_level  output  1  filtered line level.
REQ-011 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 IRDA_RXD SHALL pass through a 2-flop synchronizer, then a glitch filter; rx_level toggles only after FILT_LEN consecutive cycles where the synchronized input differs from rx_level; any agreeing cycle clears the filter count.
REQ-013 The state machine SHALL have states IDLE, LOW, HIGH and STUCK, and act only on filtered edges of rx_level.
REQ-014 IDLE: a falling edge SHALL enter LOW with the phase counter at 1; rising edges are ignored.
REQ-015 LOW: a rising edge SHALL latch the counter into low_len and enter HIGH with the counter at 1.
REQ-016 LOW: when the counter reaches IDLE_TIMEOUT, the block SHALL emit ERR once and enter STUCK.
REQ-017 STUCK: a rising edge SHALL enter IDLE and SHALL NOT emit a symbol.
REQ-018 HIGH: a falling edge SHALL latch high_len, classify, emit one symbol, and re-enter LOW with the counter at 1.
REQ-019 HIGH: when the counter reaches IDLE_TIMEOUT, the block SHALL emit IDLE (high_len = IDLE_TIMEOUT) and enter IDLE.
REQ-020 A falling edge SHALL take priority over the timeout when both occur in the same cycle.
REQ-021 Classification, checked in this order:
- LEAD: low ≥ 400000 and high ≥ 180000.
- REPEAT: low ≥ 400000 and 90000 ≤ high < 180000.
- ZERO: 20000 ≤ low ≤ 40000 and 20000 ≤ high < 41500.
- ONE: 20000 ≤ low ≤ 40000 and 41500 ≤ high ≤ 100000.
- ERR: anything else.
REQ-022 sym_valid SHALL assert exactly one cycle after the qualifying filtered edge or timeout cycle, with sym_code, low_len and high_len stable from that cycle until the next strobe.
REQ-023 The phase counter SHALL saturate at 2^20-1 and never wrap.
REQ-024 Measured lengths SHALL equal filtered-phase durations; the filter delay is equal on both edges and SHALL NOT be compensated.

Reset
REQ-025 While RESET is high:
- synchronizer flops, rx_level: 1.
- filter count, phase counter: 0.
- state: IDLE.
- sym_valid, sym_code, low_len, high_len, busy: 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without emitting any symbol.

Structure
REQ-027 Package ir_pkg SHALL hold the sym_code enum, the state enum, and all timing thresholds (400000, 180000, 90000, 20000, 40000, 41500, 100000).
REQ-028 Synchronizer plus glitch filter SHALL be sub-module ir_glitch_filter (ports CLOCK_50, RESET, din, dout).

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- NEC frame (low 450000 / high 225000 leader, 32 bits of low 28125 with high 28125 or 84375, stop low 28125) -> LEAD, 32 ZERO/ONE matching the pattern, then IDLE after 550000 high cycles.
- Low 450000 / high 112500, then low 28125 -> REPEAT, then IDLE.
- 10-cycle low glitch on an idle line -> no edge, rx_level stays 1, busy stays 0.
- Line held low 600000 cycles -> exactly one ERR at count 550000, then rising edge -> IDLE with no further symbol.
- Bit with high 45000 -> ONE; high 41499 -> ZERO; low 15000 -> ERR.
- RESET pulsed after the 10th bit -> no strobe, all outputs 0 and rx_level 1; the next full frame decodes correctly.
